// File: rtl/alarm_controller.sv
// Alarm stage fed by the 1 Hz clock counter: stores the alarm time, rings on a
// match, and handles snooze (bounded), stop, disarm and ring auto-timeout.
module alarm_controller #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_enable,
  input  logic       set_alarm,
  input  logic [4:0] alarm_hours_in,
  input  logic [5:0] alarm_minutes_in,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic [1:0] alarm_state,
  output logic [1:0] snooze_count,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RINGING  = 2'd1;
  localparam logic [1:0]  ST_SNOOZING = 2'd2;
  localparam logic [15:0] RING_LOAD   = 16'(RING_SEC - 1);
  localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SEC - 1);
  localparam logic [1:0]  MAX_CNT     = 2'(MAX_SNOOZE);

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  snooze_count_q, snooze_count_d;
  logic [4:0]  alarm_hours_q, alarm_hours_d;
  logic [5:0]  alarm_minutes_q, alarm_minutes_d;
  logic        buzzer_q, buzzer_d;
  logic        load_ok_s;
  logic        match_s;

  assign load_ok_s = set_alarm && (alarm_hours_in < 5'd24) && (alarm_minutes_in < 6'd60);
  assign match_s   = alarm_enable && (hours == alarm_hours_q) &&
                     (minutes == alarm_minutes_q) && (seconds == 6'd0);

  // State register and datapath flops
  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      timer_q         <= 16'd0;
      snooze_count_q  <= 2'd0;
      alarm_hours_q   <= 5'd0;
      alarm_minutes_q <= 6'd0;
      buzzer_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      snooze_count_q  <= snooze_count_d;
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
      buzzer_q        <= buzzer_d;
    end
  end

  // Next-state logic; a valid load overrides every event transition
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    snooze_count_d  = snooze_count_q;
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    if (load_ok_s) begin
      alarm_hours_d   = alarm_hours_in;
      alarm_minutes_d = alarm_minutes_in;
      state_d         = ST_IDLE;
      snooze_count_d  = 2'd0;
      timer_d         = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_s) begin
            state_d        = ST_RINGING;
            timer_d        = RING_LOAD;
            snooze_count_d = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RINGING: begin
          if (stop || !alarm_enable) begin
            state_d = ST_IDLE;
          end else if (snooze && (snooze_count_q < MAX_CNT)) begin
            state_d        = ST_SNOOZING;
            timer_d        = SNOOZE_LOAD;
            snooze_count_d = snooze_count_q + 2'd1;
          end else if (timer_q == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_SNOOZING: begin
          if (stop || !alarm_enable) begin
            state_d = ST_IDLE;
          end else if (timer_q == 16'd0) begin
            state_d = ST_RINGING;
            timer_d = RING_LOAD;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Buzzer is the registered decode of the next state
  always_comb begin
    if (state_d == ST_RINGING) begin
      buzzer_d = 1'b1;
    end else begin
      buzzer_d = 1'b0;
    end
  end

  assign buzzer        = buzzer_q;
  assign alarm_state   = state_q;
  assign snooze_count  = snooze_count_q;
  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a deadline-based reference model of the alarm behaviour.
module tb_alarm_controller;

  localparam int RING   = 5;
  localparam int SNOOZE = 10;
  localparam int MAXS   = 2;

  logic       Clk_1sec = 1'b0;
  logic       reset = 1'b1;
  logic       alarm_enable = 1'b0, set_alarm = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [4:0] alarm_hours_in = 5'd0;
  logic [5:0] alarm_minutes_in = 6'd0;
  logic       buzzer;
  logic [1:0] alarm_state, snooze_count;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;

  int t_h = 0, t_m = 0, t_s = 0;
  int err_cnt = 0, chk_cnt = 0;
  int cyc = 0;
  int m_mode = 0, m_cnt = 0, m_ah = 0, m_am = 0, m_deadline = 0;

  assign seconds = 6'(t_s);
  assign minutes = 6'(t_m);
  assign hours   = 5'(t_h);

  always #5 Clk_1sec = ~Clk_1sec;

  alarm_controller #(.RING_SEC(RING), .SNOOZE_SEC(SNOOZE), .MAX_SNOOZE(MAXS)) dut (
    .Clk_1sec(Clk_1sec), .reset(reset), .seconds(seconds), .minutes(minutes),
    .hours(hours), .alarm_enable(alarm_enable), .set_alarm(set_alarm),
    .alarm_hours_in(alarm_hours_in), .alarm_minutes_in(alarm_minutes_in),
    .snooze(snooze), .stop(stop), .buzzer(buzzer), .alarm_state(alarm_state),
    .snooze_count(snooze_count), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_ah = 0; m_am = 0; m_deadline = 0;
  endtask

  // Reference: modes 0 idle / 1 ringing / 2 snoozing, each phase ends at an absolute cycle
  task automatic model_step();
    bit matched;
    cyc++;
    matched = alarm_enable && t_h == m_ah && t_m == m_am && t_s == 0;
    if (set_alarm && alarm_hours_in < 24 && alarm_minutes_in < 60) begin
      m_ah = alarm_hours_in; m_am = alarm_minutes_in; m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (matched) begin m_mode = 1; m_deadline = cyc + RING; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (stop || !alarm_enable) m_mode = 0;
      else if (snooze && m_cnt < MAXS) begin m_mode = 2; m_deadline = cyc + SNOOZE; m_cnt++; end
      else if (cyc == m_deadline) m_mode = 0;
    end else begin
      if (stop || !alarm_enable) m_mode = 0;
      else if (cyc == m_deadline) begin m_mode = 1; m_deadline = cyc + RING; end
    end
  endtask

  task automatic advance_time();
    int tot;
    tot = ((t_h * 3600 + t_m * 60 + t_s) + 1) % 86400;
    t_h = tot / 3600; t_m = (tot / 60) % 60; t_s = tot % 60;
  endtask

  // Place the time two seconds before h:m:00
  task automatic jump_near(input int h, input int m);
    int tot;
    tot = (h * 3600 + m * 60 + 86400 - 2) % 86400;
    t_h = tot / 3600; t_m = (tot / 60) % 60; t_s = tot % 60;
  endtask

  task automatic cycle();
    @(posedge Clk_1sec);
    model_step();
    @(negedge Clk_1sec);
    check_eq("buzzer", int'(buzzer), (m_mode == 1) ? 1 : 0);
    check_eq("state", int'(alarm_state), m_mode);
    check_eq("snooze_count", int'(snooze_count), m_cnt);
    check_eq("alarm_hours", int'(alarm_hours), m_ah);
    check_eq("alarm_minutes", int'(alarm_minutes), m_am);
    advance_time();
  endtask

  task automatic load(input int h, input int m);
    set_alarm = 1'b1; alarm_hours_in = 5'(h); alarm_minutes_in = 6'(m);
    cycle();
    set_alarm = 1'b0;
  endtask

  task automatic ring_up(input int h, input int m);
    load(h, m);
    jump_near(h, m);
    repeat (3) cycle();
    check_eq("ring_up_buzzer", int'(buzzer), 1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge Clk_1sec);
    check_eq("reset_state", int'(alarm_state), 0);
    check_eq("reset_buzzer", int'(buzzer), 0);
    check_eq("reset_hours", int'(alarm_hours), 0);
    reset = 1'b0;
    alarm_enable = 1'b1;

    // 1: basic ring and auto-timeout from a free-running time base
    load(0, 1);
    while (!(t_m == 1 && t_s == 0)) cycle();
    cycle();
    check_eq("t1_buzzer", int'(buzzer), 1);
    check_eq("t1_state", int'(alarm_state), 1);
    n = 1;
    for (int i = 0; i < 20 && buzzer; i++) begin
      cycle();
      if (buzzer) n++;
    end
    check_eq("t1_ring_len", n, RING);
    check_eq("t1_idle", int'(alarm_state), 0);

    // 2: snooze and re-ring after SNOOZE cycles
    ring_up(0, 2);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    check_eq("t2_buzzer", int'(buzzer), 0);
    check_eq("t2_state", int'(alarm_state), 2);
    check_eq("t2_count", int'(snooze_count), 1);
    repeat (SNOOZE - 1) cycle();
    check_eq("t2_still_quiet", int'(buzzer), 0);
    cycle();
    check_eq("t2_rering", int'(buzzer), 1);

    // 3: snooze limit
    snooze = 1'b1; cycle(); snooze = 1'b0;
    repeat (SNOOZE) cycle();
    check_eq("t3_count", int'(snooze_count), 2);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    check_eq("t3_buzzer", int'(buzzer), 1);
    check_eq("t3_state", int'(alarm_state), 1);
    stop = 1'b1; cycle(); stop = 1'b0;
    check_eq("t3_stop_count_held", int'(snooze_count), 2);

    // 4: invalid load ignored, valid load while ringing
    load(24, 5);
    check_eq("t4_hours_kept", int'(alarm_hours), 0);
    check_eq("t4_minutes_kept", int'(alarm_minutes), 2);
    ring_up(1, 30);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    repeat (SNOOZE) cycle();
    load(5, 7);
    check_eq("t4_state", int'(alarm_state), 0);
    check_eq("t4_buzzer", int'(buzzer), 0);
    check_eq("t4_count", int'(snooze_count), 0);
    check_eq("t4_hours", int'(alarm_hours), 5);

    // 5: stop beats snooze; disarm while snoozing
    ring_up(2, 15);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    repeat (SNOOZE) cycle();
    stop = 1'b1; snooze = 1'b1; cycle(); stop = 1'b0; snooze = 1'b0;
    check_eq("t5_state", int'(alarm_state), 0);
    check_eq("t5_count", int'(snooze_count), 1);
    ring_up(3, 20);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    alarm_enable = 1'b0; cycle(); alarm_enable = 1'b1;
    check_eq("t5_disarm", int'(alarm_state), 0);

    // 6: asynchronous reset mid-ring
    ring_up(4, 4);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_buzzer", int'(buzzer), 0);
    check_eq("t6_state", int'(alarm_state), 0);
    check_eq("t6_hours", int'(alarm_hours), 0);
    check_eq("t6_minutes", int'(alarm_minutes), 0);
    model_reset();
    #1 reset = 1'b0;

    // Random traffic, with periodic jumps towards the stored alarm time
    for (int i = 0; i < 1500; i++) begin
      set_alarm = ($urandom_range(0, 15) == 0);
      alarm_hours_in = 5'($urandom_range(0, 31));
      alarm_minutes_in = 6'($urandom_range(0, 63));
      snooze = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 15) == 0);
      alarm_enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 24) == 0) jump_near(m_ah, m_am);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
